// File: rtl/fas_pkg.sv
// Shared constants and types for the FAS FFT analysis stage.
package fas_pkg;
  localparam int N_POINTS = 16;
  localparam int DW       = 16;
  localparam int FREQ_W   = $clog2(N_POINTS);

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } fft_word_t;

  typedef enum logic {S_IDLE, S_SCAN} state_t;
endpackage

// File: rtl/fas_peak_detect_if.sv
// FFT output bus into the peak detector, plus its result/status signals.
interface fas_peak_detect_if;
  import fas_pkg::*;

  logic              fft_valid;
  logic [2*DW-1:0]   fft_d0,  fft_d1,  fft_d2,  fft_d3,
                     fft_d4,  fft_d5,  fft_d6,  fft_d7,
                     fft_d8,  fft_d9,  fft_d10, fft_d11,
                     fft_d12, fft_d13, fft_d14, fft_d15;
  logic              done;
  logic [FREQ_W-1:0] freq;
  logic              overrun;

  modport master (
    output fft_valid,
    output fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
           fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    input  done, freq, overrun
  );

  modport slave (
    input  fft_valid,
    input  fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7,
           fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15,
    output done, freq, overrun
  );
endinterface

// File: rtl/fas_mag2.sv
// Registered squared magnitude re^2 + im^2; full precision, cannot overflow.
module fas_mag2
  import fas_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_p0,
  input  logic signed [DW-1:0] re_p0,
  input  logic signed [DW-1:0] im_p0,
  output logic                 vld_p1,
  output logic [2*DW-1:0]      mag_p1
);

  // Largest square is (-2^(DW-1))^2 = 2^(2*DW-2), which fits in 2*DW-1 bits.
  function automatic logic [2*DW-2:0] square(input logic signed [DW-1:0] x);
    logic signed [2*DW-1:0] xe;
    logic signed [2*DW-1:0] prod;
    xe   = (2*DW)'(x);
    prod = xe * xe;
    return prod[2*DW-2:0];
  endfunction

  // p0 -> p1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) mag_p1 <= {1'b0, square(re_p0)} + {1'b0, square(im_p0)};
  end
endmodule

// File: rtl/fas_peak_detect.sv
// Captures 16-point FFT frames and reports the index of the strongest bin.
module fas_peak_detect
  import fas_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  fas_peak_detect_if.slave bus
);

  localparam logic [FREQ_W-1:0] LAST = FREQ_W'(N_POINTS - 1);

  fft_word_t         frame_in [N_POINTS];
  fft_word_t         bank     [N_POINTS];
  fft_word_t         pend     [N_POINTS];
  logic              pend_full;
  state_t            state, state_nxt;
  logic [FREQ_W-1:0] cnt;
  logic              bank_free, reload, scan_vld;

  logic              vld_p1;
  logic [2*DW-1:0]   mag_p1;
  logic [FREQ_W-1:0] idx_p1;
  logic [2*DW-1:0]   max_p2;
  logic [FREQ_W-1:0] win_p2;
  logic              take;
  logic              done_r, overrun_r;
  logic [FREQ_W-1:0] freq_r;

  assign frame_in[0]  = bus.fft_d0;
  assign frame_in[1]  = bus.fft_d1;
  assign frame_in[2]  = bus.fft_d2;
  assign frame_in[3]  = bus.fft_d3;
  assign frame_in[4]  = bus.fft_d4;
  assign frame_in[5]  = bus.fft_d5;
  assign frame_in[6]  = bus.fft_d6;
  assign frame_in[7]  = bus.fft_d7;
  assign frame_in[8]  = bus.fft_d8;
  assign frame_in[9]  = bus.fft_d9;
  assign frame_in[10] = bus.fft_d10;
  assign frame_in[11] = bus.fft_d11;
  assign frame_in[12] = bus.fft_d12;
  assign frame_in[13] = bus.fft_d13;
  assign frame_in[14] = bus.fft_d14;
  assign frame_in[15] = bus.fft_d15;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_SCAN) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (reload) state_nxt = S_SCAN;
      S_SCAN:  if (cnt == LAST && !reload) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The bank is read before it is overwritten, so the last point of one frame
  // and the load of the next share an edge.
  always_comb begin
    bank_free = (state == S_IDLE) || (cnt == LAST);
    scan_vld  = (state == S_SCAN);
    reload    = bank_free && (pend_full || bus.fft_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_full <= 1'b0;
      overrun_r <= 1'b0;
    end else if (bank_free) begin
      pend_full <= pend_full && bus.fft_valid;
    end else if (bus.fft_valid) begin
      if (pend_full) overrun_r <= 1'b1;
      else           pend_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bank_free && pend_full)     bank <= pend;
    else if (bank_free && bus.fft_valid) bank <= frame_in;
    if (bus.fft_valid && (bank_free == pend_full)) pend <= frame_in;
  end

  // p0 -> p1: squared magnitude of the point addressed by cnt
  fas_mag2 u_mag2 (
    .clk    (clk),
    .rst    (rst),
    .vld_p0 (scan_vld),
    .re_p0  (bank[cnt].re),
    .im_p0  (bank[cnt].im),
    .vld_p1 (vld_p1),
    .mag_p1 (mag_p1)
  );

  always_ff @(posedge clk) begin
    if (scan_vld) idx_p1 <= cnt;
  end

  // p1 -> p2: running maximum, strict compare so the lowest index wins ties
  assign take = (idx_p1 == '0) || (mag_p1 > max_p2);

  always_ff @(posedge clk) begin
    if (vld_p1 && take) begin
      max_p2 <= mag_p1;
      win_p2 <= idx_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_r <= 1'b0;
      freq_r <= '0;
    end else begin
      done_r <= vld_p1 && (idx_p1 == LAST);
      if (vld_p1 && idx_p1 == LAST) freq_r <= take ? idx_p1 : win_p2;
    end
  end

  assign bus.done    = done_r;
  assign bus.freq    = freq_r;
  assign bus.overrun = overrun_r;
endmodule

// File: tb/tb_fas_peak_detect.sv
// Directed bench for fas_peak_detect: latency, peak index, ties, overrun, reset.
module tb_fas_peak_detect;
  import fas_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fas_peak_detect_if bus_if ();

  fas_peak_detect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  logic [31:0] frame [N_POINTS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_peak(input int k, input logic [31:0] bg, input logic [31:0] pk);
    for (int i = 0; i < N_POINTS; i++) frame[i] = bg;
    frame[k] = pk;
  endtask

  // Present the frame for exactly one rising edge; returns at the negedge after it.
  task automatic strobe();
    bus_if.fft_d0  = frame[0];  bus_if.fft_d1  = frame[1];
    bus_if.fft_d2  = frame[2];  bus_if.fft_d3  = frame[3];
    bus_if.fft_d4  = frame[4];  bus_if.fft_d5  = frame[5];
    bus_if.fft_d6  = frame[6];  bus_if.fft_d7  = frame[7];
    bus_if.fft_d8  = frame[8];  bus_if.fft_d9  = frame[9];
    bus_if.fft_d10 = frame[10]; bus_if.fft_d11 = frame[11];
    bus_if.fft_d12 = frame[12]; bus_if.fft_d13 = frame[13];
    bus_if.fft_d14 = frame[14]; bus_if.fft_d15 = frame[15];
    bus_if.fft_valid = 1'b1;
    @(negedge clk);
    bus_if.fft_valid = 1'b0;
  endtask

  // Negedges until done is seen, capped at 40.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus_if.done) break;
    end
  endtask

  initial begin
    bus_if.fft_valid = 1'b0;
    load_peak(0, 32'h0, 32'h0);
    strobe();
    bus_if.fft_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_done",    {31'd0, bus_if.done},    32'd0);
    check("reset_freq",    {28'd0, bus_if.freq},    32'd0);
    check("reset_overrun", {31'd0, bus_if.overrun}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    load_peak(5, 32'h0, {16'h0300, 16'h0400});
    strobe();
    wait_done(cyc);
    check("single_latency", cyc, 32'd17);
    check("single_freq", {28'd0, bus_if.freq}, 32'd5);
    @(negedge clk);
    check("done_one_cycle", {31'd0, bus_if.done}, 32'd0);
    check("freq_holds", {28'd0, bus_if.freq}, 32'd5);

    load_peak(0, 32'h0, 32'h0);
    strobe();
    wait_done(cyc);
    check("zero_latency", cyc, 32'd17);
    check("zero_freq", {28'd0, bus_if.freq}, 32'd0);

    load_peak(9, 32'h0, {16'h0100, 16'h0000});
    frame[3] = {16'h0100, 16'h0000};
    strobe();
    wait_done(cyc);
    check("tie_latency", cyc, 32'd17);
    check("tie_freq", {28'd0, bus_if.freq}, 32'd3);

    load_peak(12, {16'h7FFF, 16'h0000}, {16'h8000, 16'h8000});
    strobe();
    wait_done(cyc);
    check("extreme_latency", cyc, 32'd17);
    check("extreme_freq", {28'd0, bus_if.freq}, 32'd12);

    load_peak(1, 32'h0, {16'h0040, 16'h0000});
    strobe();
    @(negedge clk);
    load_peak(2, 32'h0, {16'h0040, 16'h0000});
    strobe();
    @(negedge clk);
    load_peak(7, 32'h0, {16'h0040, 16'h0000});
    strobe();
    check("overrun_set", {31'd0, bus_if.overrun}, 32'd1);
    wait_done(cyc);
    check("burst_first_latency", cyc, 32'd13);
    check("burst_first_freq", {28'd0, bus_if.freq}, 32'd1);
    wait_done(cyc);
    check("burst_spacing", cyc, 32'd16);
    check("burst_second_freq", {28'd0, bus_if.freq}, 32'd2);
    wait_done(cyc);
    check("burst_third_dropped", cyc, 32'd40);
    check("overrun_sticky", {31'd0, bus_if.overrun}, 32'd1);

    load_peak(6, 32'h0, {16'h0200, 16'h0000});
    strobe();
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_done",    {31'd0, bus_if.done},    32'd0);
    check("midreset_freq",    {28'd0, bus_if.freq},    32'd0);
    check("midreset_overrun", {31'd0, bus_if.overrun}, 32'd0);
    rst = 1'b0;
    wait_done(cyc);
    check("midreset_no_done", cyc, 32'd40);

    load_peak(9, 32'h0, {16'hFF00, 16'h0200});
    strobe();
    wait_done(cyc);
    check("post_reset_latency", cyc, 32'd17);
    check("post_reset_freq", {28'd0, bus_if.freq}, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fas_peak_detect.md
# fas_peak_detect

Analysis-stage receiver for the FFT output bus of the FAS design. It captures each 16-point frame presented on `fft_valid`/`fft_d0..fft_d15` and computes the squared magnitude of every point, one point per cycle. It then reports the index of the strongest bin on `freq` with a one-cycle `done` pulse. A one-deep pending buffer absorbs a frame that arrives while a scan is in progress.

## Interface
- `N_POINTS`, 16: points per frame; fixes the `freq` width at log2(N_POINTS).
- `DW`, 16: width of each real/imag component (signed, 8 integer + 8 fraction).
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `fft_valid`  in  1: frame strobe, one cycle per frame.
- `fft_d0..fft_d15`  in  32 each: point k, `[31:16]` real, `[15:0]` imag, two's complement.
- `done`  out  1: one-cycle pulse, result valid.
- `freq`  out  4: index of the max-magnitude bin; holds until the next `done`.
- `overrun`  out  1: sticky flag, set when a frame was dropped.

## Operation
- Reset values: `done`=0, `freq`=0, `overrun`=0; bank and pending buffer empty; FSM in IDLE.
- Capture: at an edge with `fft_valid`=1:
  - if the bank is free, the 16 words load into the bank;
  - else if the pending buffer is empty, they load into pending;
  - else the frame is dropped and `overrun` is set.
- Bank is free in IDLE, and also at the edge where point 15 is read. Read-before-write allows back-to-back frames.
- At a bank-free edge with pending full, pending moves to the bank. A simultaneous `fft_valid` then goes to pending.
- FSM:
  - IDLE -> SCAN on bank load; `cnt` = 0.
  - SCAN: each edge reads point `cnt` and registers `mag = re*re + im*im` (stage 1); `cnt`++.
  - At `cnt`=15: reload from pending or a new frame -> stay in SCAN with `cnt`=0; otherwise -> IDLE.
- Stage 2, compare: for point k=0, `max`←mag and `idx`←0. For k>0, update only when mag > `max` (strict), so on ties the lowest index wins.
- At the stage-2 edge for k=15: `freq` ← final winner (including point 15); `done` ← 1 for exactly one cycle.
- Arithmetic: each square is 31 bits unsigned (max 2^30 for −32768). The sum is 32 bits unsigned and cannot overflow. No rounding or truncation.
- Reset mid-scan: all state cleared immediately; no `done` for the abandoned frame; `freq` returns to 0.

## Timing
- Frame captured at edge E0. Point k's magnitude is registered at E(k+1). Compare for point k happens at E(k+2).
- `done`=1 and `freq` valid after E17: latency 17 cycles from the capture edge.
- Sustained throughput: one frame per 16 cycles with no drop.
- Frames spaced at 16 cycles produce `done` pulses spaced at 16 cycles.
- `overrun` is never cleared except by `rst`.

## Structure
- Shared package `fas_pkg`: `N_POINTS`, `DW`, and typedef `fft_word_t` (packed struct {logic signed [DW-1:0] re, im}).
- Sub-module `fas_mag2`: registered re²+im² squarer (stage 1), instantiated once.
- Top contains the bank, pending buffer, FSM/counter, compare stage and flags.

## Test plan
- Single frame, all points 0 except point 5 = {0x0300,0x0400} -> `done` 17 cycles after the strobe; `freq`=5.
- All-zero frame -> `done` pulse; `freq`=0 (tie, lowest index).
- Points 3 and 9 both {0x0100,0x0000}, others zero -> `freq`=3.
- Point 12 = {0x8000,0x8000}, others {0x7FFF,0x0000} -> `freq`=12, with no overflow.
- Three frames strobed 2 cycles apart (peaks at 1, 2, 7) -> two `done` pulses 16 cycles apart with `freq`=1 then 2; third frame dropped; `overrun`=1.
- Reset asserted at cycle E8 of a scan -> no `done`; `freq`=0; `overrun`=0; a new frame afterwards scans normally.
